ws2812b_in_module: RTL and testbench

- Receiver/decoder for the single-wire WS2812B LED protocol. Samples a serial data line and measures high-pulse widths to decode bits into 24-bit words, MSB first. Detects the low "latch" gap that ends a frame.
- Used to loop back and check the LED driver output on the board, and to accept LED data from an upstream controller.
- Also drives a chained-LED pass-through, compile-time optional.

---
 rtl/ws2812b_in_module.sv | 182 ++++++++++++++++++
 tb/tb_ws2812b_in_module.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_in_module.sv
// WS2812B single-wire receiver: decodes 24-bit MSB-first words and detects the latch gap.
// Define WS2812B_IN_FORWARD_EN to build the chained-LED pass-through on ws2812b_dout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_SYNC | waiting for a full latch gap before trusting the line
// ST_LOW  | line low between pulses; watching for rise or latch gap
// ST_HIGH | line high; measuring pulse width for the bit decision
module ws2812b_in_module #(
   parameter int CYCLES_BIT_THRESH = 5,
   parameter int CYCLES_HIGH_MAX   = 12,
   parameter int CYCLES_RET_MIN    = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ws2812b_din,
   output logic [23:0] bitstream,
   output logic        bitstream_valid,
   output logic        frame_end,
   output logic        rx_error,
   output logic [7:0]  word_count,
   output logic        ws2812b_dout,
   output logic [3:0]  debug_info
);

   localparam int LOW_W  = $clog2(CYCLES_RET_MIN + 1);
   localparam int HIGH_W = $clog2(CYCLES_HIGH_MAX + 1);
   localparam logic [LOW_W-1:0]  RET_MIN    = LOW_W'(CYCLES_RET_MIN);
   localparam logic [HIGH_W-1:0] HIGH_MAX   = HIGH_W'(CYCLES_HIGH_MAX);
   localparam logic [HIGH_W-1:0] BIT_THRESH = HIGH_W'(CYCLES_BIT_THRESH);

   typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH} state_t;

   state_t              state, state_nxt;
   logic                din_meta, din_sync, din_prev;
   logic [LOW_W-1:0]    low_cnt, low_nxt;
   logic [HIGH_W-1:0]   high_cnt, high_nxt;
   logic [4:0]          bit_cnt, bit_nxt;
   logic [22:0]         shreg, shreg_nxt;
   logic [7:0]          word_cnt, word_nxt;
   logic [23:0]         bitstream_q, bitstream_nxt;
   logic                valid_q, valid_nxt;
   logic                fe_q, fe_nxt;
   logic                err_q, err_nxt;
   logic                rise, fall, bit_val;

   assign rise    = din_sync & ~din_prev;
   assign fall    = ~din_sync & din_prev;
   assign bit_val = (high_cnt >= BIT_THRESH);

   always_ff @(posedge clk) begin
      if (reset) begin
         din_meta    <= 1'b0;
         din_sync    <= 1'b0;
         din_prev    <= 1'b0;
         state       <= ST_SYNC;
         low_cnt     <= '0;
         high_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         word_cnt    <= '0;
         bitstream_q <= '0;
         valid_q     <= 1'b0;
         fe_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         din_meta    <= ws2812b_din;
         din_sync    <= din_meta;
         din_prev    <= din_sync;
         state       <= state_nxt;
         low_cnt     <= low_nxt;
         high_cnt    <= high_nxt;
         bit_cnt     <= bit_nxt;
         shreg       <= shreg_nxt;
         word_cnt    <= word_nxt;
         bitstream_q <= bitstream_nxt;
         valid_q     <= valid_nxt;
         fe_q        <= fe_nxt;
         err_q       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      low_nxt       = low_cnt;
      high_nxt      = high_cnt;
      bit_nxt       = bit_cnt;
      shreg_nxt     = shreg;
      word_nxt      = word_cnt;
      bitstream_nxt = bitstream_q;
      valid_nxt     = 1'b0;
      fe_nxt        = 1'b0;
      err_nxt       = 1'b0;
      case (state)
         ST_SYNC: begin
            if (din_sync) begin
               low_nxt = '0;
            end else if (low_cnt == RET_MIN - LOW_W'(1)) begin
               // Enter LOW already saturated so this gap raises no latch event
               low_nxt   = RET_MIN;
               state_nxt = ST_LOW;
            end else begin
               low_nxt = low_cnt + LOW_W'(1);
            end
         end
         ST_LOW: begin
            if (rise) begin
               state_nxt = ST_HIGH;
               high_nxt  = HIGH_W'(1);
               low_nxt   = '0;
            end else if (low_cnt != RET_MIN) begin
               low_nxt = low_cnt + LOW_W'(1);
               if (low_cnt == RET_MIN - LOW_W'(1)) begin
                  if (bit_cnt != 5'd0) begin
                     err_nxt = 1'b1;
                  end else if (word_cnt != 8'd0) begin
                     fe_nxt = 1'b1;
                  end
                  bit_nxt  = '0;
                  word_nxt = '0;
               end
            end
         end
         ST_HIGH: begin
            if (fall) begin
               shreg_nxt = {shreg[21:0], bit_val};
               if (bit_cnt == 5'd23) begin
                  bitstream_nxt = {shreg, bit_val};
                  valid_nxt     = 1'b1;
                  bit_nxt       = '0;
                  if (word_cnt != 8'hFF) begin
                     word_nxt = word_cnt + 8'd1;
                  end
               end else begin
                  bit_nxt = bit_cnt + 5'd1;
               end
               // The falling-edge sample is the first low cycle of the gap
               low_nxt   = LOW_W'(1);
               state_nxt = ST_LOW;
            end else if (high_cnt >= HIGH_MAX) begin
               err_nxt   = 1'b1;
               bit_nxt   = '0;
               word_nxt  = '0;
               low_nxt   = '0;
               state_nxt = ST_SYNC;
            end else begin
               high_nxt = high_cnt + HIGH_W'(1);
            end
         end
         default: begin
            state_nxt = ST_SYNC;
         end
      endcase
   end

`ifdef WS2812B_IN_FORWARD_EN
   logic fwd_active;

   // Forwarding opens after the first word of a frame and closes at its end
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_active <= 1'b0;
      end else if (err_nxt || fe_nxt) begin
         fwd_active <= 1'b0;
      end else if (valid_nxt) begin
         fwd_active <= 1'b1;
      end
   end

   assign ws2812b_dout = fwd_active & din_prev;
`else
   assign ws2812b_dout = 1'b0;
`endif

   assign bitstream       = bitstream_q;
   assign bitstream_valid = valid_q;
   assign frame_end       = fe_q;
   assign rx_error        = err_q;
   assign word_count      = word_cnt;
   assign debug_info      = {din_sync, valid_q, fe_q, err_q};

endmodule

// File: tb/tb_ws2812b_in_module.sv
// Self-checking bench for ws2812b_in_module: table of words plus hand-written corner sequences.
// Expected words are queued when driven and popped when bitstream_valid fires.
module tb_ws2812b_in_module;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws2812b_din;
   logic [23:0] bitstream;
   logic        bitstream_valid;
   logic        frame_end;
   logic        rx_error;
   logic [7:0]  word_count;
   logic        ws2812b_dout;
   logic [3:0]  debug_info;

   always #5 clk = ~clk;

   ws2812b_in_module dut (
      .clk             (clk),
      .reset           (reset),
      .ws2812b_din     (ws2812b_din),
      .bitstream       (bitstream),
      .bitstream_valid (bitstream_valid),
      .frame_end       (frame_end),
      .rx_error        (rx_error),
      .word_count      (word_count),
      .ws2812b_dout    (ws2812b_dout),
      .debug_info      (debug_info)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [23:0] exp_q[$];
   int valid_cnt = 0;
   int fe_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int last_valid_cyc = 0;
   int fe_delta = -1;
   logic rst_q = 1'b1;
   logic rst_qq = 1'b1;
   logic [3:0] hist = 4'd0;
   logic fwd_mode = 1'b0;
   logic [23:0] exp_word;

   typedef struct {
      logic [23:0] data;
      int          one_high;
      logic [7:0]  exp_wc;
      int          gap;
      int          exp_fe;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int one_high);
      ws2812b_din = 1'b1;
      repeat (b ? one_high : 4) tick();
      ws2812b_din = 1'b0;
      repeat (b ? 4 : 6) tick();
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[23 - i], 6);
   endtask

   task automatic send_word(input logic [23:0] w, input int one_high, input logic fwd);
      fwd_mode = fwd;
      exp_q.push_back(w);
      for (int i = 23; i >= 0; i--) send_bit(w[i], one_high);
   endtask

   task automatic low(input int n);
      ws2812b_din = 1'b0;
      repeat (n) tick();
   endtask

   always @(posedge clk) begin
      rst_qq <= rst_q;
      rst_q  <= reset;
   end

   // Monitor: strobes, scoreboard pops, synchronizer and pass-through checks
   always @(negedge clk) begin
      cyc++;
      hist = {hist[2:0], ws2812b_din};
      if (rst_q || rst_qq) begin
         chk("strobes_in_reset", {29'd0, bitstream_valid, frame_end, rx_error}, 32'd0);
      end else begin
         if (bitstream_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got word %06h, expected no word (t=%0t)", bitstream, $time);
            end else begin
               exp_word = exp_q.pop_front();
               chk("bitstream", {8'd0, bitstream}, {8'd0, exp_word});
            end
         end
         if (frame_end) begin
            fe_cnt++;
            fe_delta = cyc - last_valid_cyc;
         end
         if (rx_error) err_cnt++;
         chk("din_sync", {31'd0, debug_info[3]}, {31'd0, hist[2]});
      end
`ifdef WS2812B_IN_FORWARD_EN
      chk("dout", {31'd0, ws2812b_dout}, {31'd0, fwd_mode & hist[3]});
`else
      chk("dout", {31'd0, ws2812b_dout}, 32'd0);
`endif
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      int v0, fe0, e0;
      vecs[0] = '{24'hA5C3F0, 6,  8'd1, 450, 1};
      vecs[1] = '{24'hFF0000, 6,  8'd1, 0,   1};
      vecs[2] = '{24'h00FF00, 5,  8'd2, 0,   1};
      vecs[3] = '{24'h0000FF, 12, 8'd3, 450, 2};

      // Reset with the line high: synchronizer must still read 0
      reset = 1'b1;
      ws2812b_din = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_word_count", {24'd0, word_count}, 32'd0);
      chk("rst_bitstream", {8'd0, bitstream}, 32'd0);
      chk("rst_debug", {28'd0, debug_info}, 32'd0);
      chk("rst_dout", {31'd0, ws2812b_dout}, 32'd0);
      tick();
      ws2812b_din = 1'b0;
      tick();
      reset = 1'b0;
      low(210);

      // Table: single-word frame, then three back-to-back words (threshold and max-high boundaries)
      v0 = valid_cnt;
      for (int i = 0; i < 4; i++) begin
         send_word(vecs[i].data, vecs[i].one_high, vecs[i].exp_wc > 8'd1);
         chk("tbl_word_count", {24'd0, word_count}, {24'd0, vecs[i].exp_wc});
         chk("tbl_valid_cnt", valid_cnt, v0 + i + 1);
         if (vecs[i].gap > 0) begin
            low(vecs[i].gap);
            chk("tbl_fe_cnt", fe_cnt, vecs[i].exp_fe);
            chk("tbl_fe_delay", fe_delta, 199);
            chk("tbl_wc_after_gap", {24'd0, word_count}, 32'd0);
         end
      end
      chk("tbl_err_cnt", err_cnt, 0);
      chk("bitstream_held", {8'd0, bitstream}, 32'h0000FF);

      // Reset mid-frame, released while data keeps toggling
      v0 = valid_cnt; fe0 = fe_cnt; e0 = err_cnt;
      send_bits(24'hFFFFFF, 5);
      reset = 1'b1;
      send_bits(24'hA00000, 2);
      reset = 1'b0;
      send_bits(24'hF0F0F0, 24);
      send_bits(24'hAAAAAA, 8);
      chk("midrst_no_valid", valid_cnt, v0);
      chk("midrst_wc", {24'd0, word_count}, 32'd0);
      low(210);
      chk("midrst_no_fe", fe_cnt, fe0);
      chk("midrst_no_err", err_cnt, e0);
      send_word(24'h5A5A5A, 6, 1'b0);
      chk("midrst_wc1", {24'd0, word_count}, 32'd1);
      low(450);
      chk("midrst_fe", fe_cnt, fe0 + 1);
      chk("midrst_valid", valid_cnt, v0 + 1);

      // Partial word at latch
      v0 = valid_cnt; fe0 = fe_cnt; e0 = err_cnt;
      send_bits(24'hABCDEF, 10);
      low(210);
      chk("partial_err", err_cnt, e0 + 1);
      chk("partial_no_fe", fe_cnt, fe0);
      chk("partial_no_valid", valid_cnt, v0);
      chk("partial_bitstream", {8'd0, bitstream}, 32'h5A5A5A);
      chk("partial_wc", {24'd0, word_count}, 32'd0);

      // Over-long high pulse mid-word, then recovery after a gap
      v0 = valid_cnt; fe0 = fe_cnt; e0 = err_cnt;
      send_bits(24'hFFFFFF, 5);
      ws2812b_din = 1'b1;
      repeat (13) tick();
      low(10);
      send_bits(24'h0F0F0F, 24);
      chk("long_err", err_cnt, e0 + 1);
      chk("long_no_valid", valid_cnt, v0);
      low(210);
      chk("long_err_once", err_cnt, e0 + 1);
      chk("long_wc", {24'd0, word_count}, 32'd0);
      send_word(24'h123456, 6, 1'b0);
      low(450);
      chk("long_valid", valid_cnt, v0 + 1);
      chk("long_fe", fe_cnt, fe0 + 1);

      // Pass-through frame followed by a new frame whose first word must not forward
      v0 = valid_cnt; fe0 = fe_cnt;
      send_word(24'h111111, 6, 1'b0);
      chk("fwd_wc1", {24'd0, word_count}, 32'd1);
      send_word(24'h222222, 6, 1'b1);
      chk("fwd_wc2", {24'd0, word_count}, 32'd2);
      low(450);
      send_word(24'h333333, 6, 1'b0);
      low(450);
      chk("fwd_valid", valid_cnt, v0 + 3);
      chk("fwd_fe", fe_cnt, fe0 + 2);

      chk("queue_drained", exp_q.size(), 0);
      chk("total_valid", valid_cnt, 9);
      chk("total_err", err_cnt, 2);
      chk("total_fe", fe_cnt, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
